// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } state_e;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_EXT = 1'b1;

  localparam int unsigned MAX_LAT = 15;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

endpackage

// File: rtl/arb_pick2.sv
// Two-way requester picker. Define MEM_ARB_RR_EN for round-robin on ties;
// otherwise ext has fixed priority over cpu.
module arb_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       winner
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    winner = GNT_CPU;
    if (req[GNT_EXT] && req[GNT_CPU]) begin
      winner = ~last_owner;
    end else if (req[GNT_EXT]) begin
      winner = GNT_EXT;
    end
  end
`else
  // Fixed priority only needs the ext request bit.
  logic [1:0] unused_pick_inputs;
  assign unused_pick_inputs = {last_owner, req[GNT_CPU]};
  assign winner = req[GNT_EXT] ? GNT_EXT : GNT_CPU;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory between the CPU controller and an external loader port.
// MEM_ARB_RR_EN selects round-robin tie-breaking (fixed ext priority otherwise).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_ext
);

  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(MEM_LAT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              grant_ext_q, grant_ext_d;
  logic              winner, last_owner, grant;

  assign grant = (state_q == StIdle) && (cpu_req || ext_req);

  arb_pick2 u_pick (
    .req       ({ext_req, cpu_req}),
    .last_owner(last_owner),
    .winner    (winner)
  );

`ifdef MEM_ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner <= GNT_CPU;
    end else if (grant) begin
      last_owner <= winner;
    end
  end
`else
  assign last_owner = GNT_CPU;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    grant_ext_d = grant_ext_q;
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          state_d     = StAccess;
          cnt_d       = CntLoad;
          grant_ext_d = winner;
          we_d        = (winner == GNT_EXT) ? ext_we    : cpu_we;
          addr_d      = (winner == GNT_EXT) ? ext_addr  : cpu_addr;
          wdata_d     = (winner == GNT_EXT) ? ext_wdata : cpu_wdata;
        end
      end
      StAccess: begin
        if (cnt_q == '0) begin
          // Memory read data is only guaranteed in the final enable cycle.
          if (!we_q) rdata_d = mem_rdata;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      grant_ext_q <= GNT_CPU;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      grant_ext_q <= grant_ext_d;
    end
  end

  assign mem_en    = (state_q == StAccess);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = mem_en ? addr_q : '0;
  assign mem_wdata = mem_en ? wdata_q : '0;
  assign cpu_ack   = (state_q == StDone) && (grant_ext_q == GNT_CPU);
  assign ext_ack   = (state_q == StDone) && (grant_ext_q == GNT_EXT);
  assign busy      = (state_q != StIdle);
  assign grant_ext = grant_ext_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: scoreboard of expected ack owner/rdata.
module tb_mem_port_arbiter;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0, ext_req = 1'b0, ext_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0, ext_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, ext_wdata = '0;
  logic          cpu_ack, ext_ack, mem_en, mem_we, busy, grant_ext;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_ack  (cpu_ack),
    .ext_req  (ext_req),
    .ext_we   (ext_we),
    .ext_addr (ext_addr),
    .ext_wdata(ext_wdata),
    .ext_ack  (ext_ack),
    .rdata    (rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .grant_ext(grant_ext)
  );

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  assign mem_rdata = (mem_en && !mem_we) ? rom(mem_addr) : 32'h0BADF00D;

  typedef struct packed {
    logic        ext;
    logic [31:0] rd;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_rd = '0;
  int          vecs = 0;
  int          errs = 0;

  // Expected read-data register contents at ack: writes leave it unchanged.
  task automatic push_exp(input logic ext, input logic we, input logic [31:0] addr);
    exp_t e;
    if (!we) last_rd = rom(addr);
    e.ext = ext;
    e.rd  = last_rd;
    sb.push_back(e);
  endtask

  // Runs one granted access from its IDLE grant cycle (k=0) through the following IDLE cycle,
  // scrambling requester fields once ACCESS has started and dropping req at ack.
  task automatic observe(input logic we_e, input logic [31:0] addr_e, input logic [31:0] wdata_e,
                         input int drop_k, output int en_n, output int bad_n, output int ack_k,
                         output int ack_n, output logic ack_ext, output logic [31:0] rd);
    logic saw;
    en_n = 0; bad_n = 0; ack_k = -1; ack_n = 0; ack_ext = 1'b0; rd = '0;
    for (int k = 0; k <= int'(LAT) + 2; k++) begin
      @(negedge clk);
      if (mem_en) begin
        en_n++;
        if (mem_we !== we_e || mem_addr !== addr_e || (we_e && mem_wdata !== wdata_e)) bad_n++;
      end
      saw = cpu_ack | ext_ack;
      ack_n += int'(cpu_ack) + int'(ext_ack);
      if (saw && ack_k < 0) begin
        ack_k = k; ack_ext = ext_ack; rd = rdata;
      end
      @(posedge clk); #1;
      if (k == 1) begin
        cpu_addr ^= 32'h30; ext_addr ^= 32'h30;
        cpu_wdata = ~cpu_wdata; ext_wdata = ~ext_wdata;
      end
      if (saw || k == drop_k) begin
        cpu_req = 1'b0; ext_req = 1'b0;
      end
    end
    cpu_req = 1'b0; ext_req = 1'b0;
  endtask

  task automatic test_reset();
    cpu_req = 1'b1;
    repeat (2) @(negedge clk);
    vecs++;
    if ({cpu_ack, ext_ack, mem_en, mem_we, busy, grant_ext} !== 6'b0) begin
      errs++; $display("FAIL reset_ctrl: got %b want 000000",
                       {cpu_ack, ext_ack, mem_en, mem_we, busy, grant_ext});
    end
    vecs++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      errs++; $display("FAIL reset_mem_bus: got addr %h wdata %h want 0", mem_addr, mem_wdata);
    end
    vecs++;
    if (rdata !== '0) begin
      errs++; $display("FAIL reset_rdata: got %h want 0", rdata);
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_arbitration();
    exp_t e;
    int   got = 0;
    int   prev_k = -1;
    cpu_we = 1'b0; ext_we = 1'b0; cpu_addr = 32'h100; ext_addr = 32'h200;
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_RR_EN
      push_exp((i % 2) == 0, 1'b0, ((i % 2) == 0) ? 32'h200 : 32'h100);
`else
      push_exp(1'b1, 1'b0, 32'h200);
`endif
    end
    cpu_req = 1'b1; ext_req = 1'b1;
    for (int k = 0; k < 40 && got < 4; k++) begin
      @(negedge clk);
      if (cpu_ack || ext_ack) begin
        vecs++;
        if (cpu_ack && ext_ack) begin
          errs++; $display("FAIL arb_dual_ack: got both acks want one");
        end
        e = sb.pop_front();
        vecs++;
        if (ext_ack !== e.ext) begin
          errs++; $display("FAIL arb_owner #%0d: got ext_ack %b want %b", got, ext_ack, e.ext);
        end
        vecs++;
        if (rdata !== e.rd) begin
          errs++; $display("FAIL arb_rdata #%0d: got %h want %h", got, rdata, e.rd);
        end
        if (prev_k >= 0) begin
          vecs++;
          if (k - prev_k !== int'(LAT) + 2) begin
            errs++; $display("FAIL arb_spacing: got %0d want %0d", k - prev_k, LAT + 2);
          end
        end
        prev_k = k; got++;
      end
      @(posedge clk); #1;
    end
    cpu_req = 1'b0; ext_req = 1'b0;
    vecs++;
    if (got != 4) begin
      errs++; $display("FAIL arb_timeout: got %0d acks want 4", got);
    end
    sb.delete();
    @(posedge clk); #1;
  endtask

  task automatic check_access(input string name, input logic we_e, input logic [31:0] addr_e,
                              input logic [31:0] wdata_e, input int drop_k);
    int          en_n, bad_n, ack_k, ack_n;
    logic        ack_ext;
    logic [31:0] rd;
    exp_t        e;
    observe(we_e, addr_e, wdata_e, drop_k, en_n, bad_n, ack_k, ack_n, ack_ext, rd);
    e = sb.pop_front();
    vecs++;
    if (en_n != int'(LAT) || bad_n != 0) begin
      errs++; $display("FAIL %s_mem: got en %0d bad %0d want en %0d bad 0", name, en_n, bad_n, LAT);
    end
    vecs++;
    if (ack_k != int'(LAT) + 1 || ack_n != 1) begin
      errs++; $display("FAIL %s_ack: got cycle %0d count %0d want cycle %0d count 1",
                       name, ack_k, ack_n, LAT + 1);
    end
    vecs++;
    if (ack_ext !== e.ext) begin
      errs++; $display("FAIL %s_owner: got ext_ack %b want %b", name, ack_ext, e.ext);
    end
    vecs++;
    if (rd !== e.rd) begin
      errs++; $display("FAIL %s_rdata: got %h want %h", name, rd, e.rd);
    end
  endtask

  task automatic test_cpu_read();
    cpu_we = 1'b0; cpu_addr = 32'h10; cpu_req = 1'b1;
    push_exp(1'b0, 1'b0, 32'h10);
    check_access("cpu_read", 1'b0, 32'h10, 32'h0, -1);
  endtask

  task automatic test_ext_write();
    ext_we = 1'b1; ext_addr = 32'h40; ext_wdata = 32'h12345678; ext_req = 1'b1;
    push_exp(1'b1, 1'b1, 32'h40);
    check_access("ext_write", 1'b1, 32'h40, 32'h12345678, -1);
  endtask

  task automatic test_field_change();
    cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hCAFE0001; cpu_req = 1'b1;
    push_exp(1'b0, 1'b1, 32'h10);
    check_access("field_change", 1'b1, 32'h10, 32'hCAFE0001, -1);
  endtask

  task automatic test_req_drop();
    cpu_we = 1'b0; cpu_addr = 32'h80; cpu_req = 1'b1;
    push_exp(1'b0, 1'b0, 32'h80);
    check_access("req_drop", 1'b0, 32'h80, 32'h0, 1);
  endtask

  task automatic test_reset_mid_access();
    ext_we = 1'b1; ext_addr = 32'h44; ext_wdata = 32'hA5A5A5A5; ext_req = 1'b1;
    @(posedge clk); #1;
    vecs++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1) begin
      errs++; $display("FAIL rstmid_started: got en %b we %b want 1 1", mem_en, mem_we);
    end
    rst = 1'b1; ext_req = 1'b0;
    #1;
    vecs++;
    if ({cpu_ack, ext_ack, mem_en, mem_we, busy, grant_ext} !== 6'b0 ||
        mem_addr !== '0 || mem_wdata !== '0 || rdata !== '0) begin
      errs++; $display("FAIL rstmid_outputs: got ctrl %b addr %h wdata %h rdata %h want all 0",
                       {cpu_ack, ext_ack, mem_en, mem_we, busy, grant_ext}, mem_addr, mem_wdata,
                       rdata);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vecs++;
      if (cpu_ack || ext_ack || busy) begin
        errs++; $display("FAIL rstmid_quiet: got ack %b%b busy %b want 0", cpu_ack, ext_ack, busy);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete(); last_rd = '0;
    @(posedge clk); #1;
    cpu_we = 1'b0; cpu_addr = 32'h24; cpu_req = 1'b1;
    push_exp(1'b0, 1'b0, 32'h24);
    check_access("rstmid_after", 1'b0, 32'h24, 32'h0, -1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_arbitration();
    test_cpu_read();
    test_ext_write();
    test_field_change();
    test_req_drop();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
